// File: rtl/ysyx_25040129_wbu_pkg.sv
// Shared definitions for the writeback unit: register-index width and the
// writeback FSM state encoding. Imported by ysyx_25040129_wbu and its
// scoreboard-compare sub-module.
`ifndef ysyx_25040129_REGS_DIG
`define ysyx_25040129_REGS_DIG 4
`endif

package ysyx_25040129_wbu_pkg;

  // Register-index width: 16 architectural registers, x0 hardwired to zero.
  localparam int WBU_REGS_DIG = `ysyx_25040129_REGS_DIG;

  typedef enum logic [1:0] {
    WBU_IDLE    = 2'd0,
    WBU_WAIT_LD = 2'd1,
    WBU_WB      = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_25040129_wbu_sb.sv
// Scoreboard compare: flags that the held writeback targets the queried register.
// Ports: hold_wen_i/hold_rd_i (request in flight), q_id_i (decode query), match_o.
// Purely combinational; x0 never matches because it is never written.
module ysyx_25040129_wbu_sb
  import ysyx_25040129_wbu_pkg::*;
#(
  parameter int REGS_DIG = WBU_REGS_DIG
) (
  input  logic                hold_wen_i,
  input  logic [REGS_DIG-1:0] hold_rd_i,
  input  logic [REGS_DIG-1:0] q_id_i,
  output logic                match_o
);

  assign match_o = hold_wen_i && (hold_rd_i != '0) && (hold_rd_i == q_id_i);

endmodule

// File: rtl/ysyx_25040129_wbu.sv
// Writeback unit: holds one EXU result (or waits for LSU load data), then
// writes it to the register file for one cycle and pulses commit.
// Ports: in_* request handshake from EXU, lsu_* load return, rd/reg_write/result
// register-file write port, qN_id/qN_busy scoreboard query, fwdN_* bypass, commit.
// Latency: non-load retires the cycle after acceptance; load the cycle after
// lsu_rvalid. Backpressure: in_ready only in IDLE (one request per 2 cycles min).
// Optional bypass enabled by defining YSYX_25040129_WBU_FWD_EN; otherwise the
// fwd outputs are tied to zero.
module ysyx_25040129_wbu
  import ysyx_25040129_wbu_pkg::*;
#(
  parameter int REGS_DIG = WBU_REGS_DIG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REGS_DIG-1:0] in_rd,
  input  logic                in_wen,
  input  logic                in_is_load,
  input  logic [31:0]         in_result,
  input  logic                lsu_rvalid,
  input  logic [31:0]         lsu_rdata,
  output logic [REGS_DIG-1:0] rd,
  output logic                reg_write,
  output logic [31:0]         result,
  input  logic [REGS_DIG-1:0] q1_id,
  input  logic [REGS_DIG-1:0] q2_id,
  output logic                q1_busy,
  output logic                q2_busy,
  output logic                fwd1_valid,
  output logic                fwd2_valid,
  output logic [31:0]         fwd1_data,
  output logic [31:0]         fwd2_data,
  output logic                commit
);

  wbu_state_e          state_q, state_d;
  logic [REGS_DIG-1:0] hold_rd_q;
  logic                hold_wen_q;
  logic [31:0]         hold_result_q;
  logic [REGS_DIG-1:0] rd_q;
  logic [31:0]         result_q;

  logic                accept;
  logic                ld_done;
  logic                q1_match, q2_match;

  assign accept  = (state_q == WBU_IDLE) && in_valid;
  assign ld_done = (state_q == WBU_WAIT_LD) && lsu_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WBU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    commit    = 1'b0;
    reg_write = 1'b0;
    unique case (state_q)
      WBU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_is_load ? WBU_WAIT_LD : WBU_WB;
      end
      WBU_WAIT_LD: begin
        if (lsu_rvalid) state_d = WBU_WB;
      end
      WBU_WB: begin
        commit    = 1'b1;
        reg_write = hold_wen_q && (hold_rd_q != '0);
        state_d   = WBU_IDLE;
      end
      default: state_d = WBU_IDLE;
    endcase
  end

  // rd/result are registered copies loaded on the edge that enters WB, so they
  // show the retiring request in WB and keep their last value everywhere else
  // (a newly accepted load does not disturb them while it waits).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_rd_q     <= '0;
      hold_wen_q    <= 1'b0;
      hold_result_q <= '0;
      rd_q          <= '0;
      result_q      <= '0;
    end else if (accept) begin
      hold_rd_q     <= in_rd;
      hold_wen_q    <= in_wen;
      hold_result_q <= in_result;
      if (!in_is_load) begin
        rd_q     <= in_rd;
        result_q <= in_result;
      end
    end else if (ld_done) begin
      hold_result_q <= lsu_rdata;
      rd_q          <= hold_rd_q;
      result_q      <= lsu_rdata;
    end
  end

  assign rd     = rd_q;
  assign result = result_q;

  ysyx_25040129_wbu_sb #(.REGS_DIG(REGS_DIG)) u_sb1 (
    .hold_wen_i (hold_wen_q),
    .hold_rd_i  (hold_rd_q),
    .q_id_i     (q1_id),
    .match_o    (q1_match)
  );

  ysyx_25040129_wbu_sb #(.REGS_DIG(REGS_DIG)) u_sb2 (
    .hold_wen_i (hold_wen_q),
    .hold_rd_i  (hold_rd_q),
    .q_id_i     (q2_id),
    .match_o    (q2_match)
  );

  assign q1_busy = (state_q != WBU_IDLE) && q1_match;
  assign q2_busy = (state_q != WBU_IDLE) && q2_match;

`ifdef YSYX_25040129_WBU_FWD_EN
  // Only WB holds final data; in WAIT_LD the load value is not yet known.
  assign fwd1_valid = (state_q == WBU_WB) && q1_match;
  assign fwd2_valid = (state_q == WBU_WB) && q2_match;
  assign fwd1_data  = hold_result_q;
  assign fwd2_data  = hold_result_q;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = '0;
  assign fwd2_data  = '0;
`endif

endmodule
